// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared state, opcode, command and ALU encodings for the multicycle control path
package ctrl_pkg;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, UNKNOWN
  } state_t;
  localparam logic [3:0] PC_REG  = 4'd15;
  localparam int         ALUCTL_W = 2;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [ALUCTL_W-1:0] ALU_ADD = 2'b00;
  localparam logic [ALUCTL_W-1:0] ALU_SUB = 2'b01;
  localparam logic [ALUCTL_W-1:0] ALU_AND = 2'b10;
  localparam logic [ALUCTL_W-1:0] ALU_ORR = 2'b11;
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
endpackage

// File: rtl/multicycle_control_fsm_alu_decoder.sv
// alu_decoder: maps the data-processing cmd/S fields to ALU operation, flag writes and NoWrite
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [5:0]          Funct,
  input  logic                ALUOp,
  output logic [ALUCTL_W-1:0] ALUControl,
  output logic [1:0]          FlagW,
  output logic                NoWrite
);
  logic [ALUCTL_W-1:0] ctl;
  logic [1:0]          fw;
  logic                s;
  assign s = Funct[0];
  always_comb begin
    ctl     = ALU_ADD;
    fw      = 2'b00;
    NoWrite = 1'b1;
    case (Funct[4:1])
      CMD_ADD: begin ctl = ALU_ADD; fw = s ? 2'b11 : 2'b00; NoWrite = 1'b0; end
      CMD_SUB: begin ctl = ALU_SUB; fw = s ? 2'b11 : 2'b00; NoWrite = 1'b0; end
      CMD_AND: begin ctl = ALU_AND; fw = s ? 2'b10 : 2'b00; NoWrite = 1'b0; end
      CMD_ORR: begin ctl = ALU_ORR; fw = s ? 2'b10 : 2'b00; NoWrite = 1'b0; end
      CMD_CMP: begin ctl = ALU_SUB; fw = 2'b11; end
      default: ;
    endcase
  end
  // Outside the execute states the ALU is only used for address/PC arithmetic.
  assign ALUControl = ALUOp ? ctl : ALU_ADD;
  assign FlagW      = ALUOp ? fw : 2'b00;
endmodule

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: Moore sequencer and field decode driving the multicycle datapath
module multicycle_control_fsm
  import ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          Op,
  input  logic [5:0]          Funct,
  input  logic [3:0]          Rd,
  output logic                IRWrite,
  output logic                NextPC,
  output logic                AdrSrc,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          ResultSrc,
  output logic [ALUCTL_W-1:0] ALUControl,
  output logic [1:0]          ImmSrc,
  output logic [1:0]          RegSrc,
  output logic                PCS,
  output logic                RegW,
  output logic                MemW,
  output logic                NoWrite,
  output logic [1:0]          FlagW
);
  state_t     state;
  logic       exec, wb, dec_nw;
  logic [1:0] dec_fw;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= FETCH;
    else
      case (state)
        FETCH:   state <= DECODE;
        DECODE:  state <= Op == OP_MEM ? MEMADR :
                          Op == OP_DP  ? (Funct[5] ? EXECI : EXECR) :
                          Op == OP_BR  ? BRANCH : UNKNOWN;
        MEMADR:  state <= Funct[0] ? MEMRD : MEMWR;
        MEMRD:   state <= MEMWB;
        EXECR,
        EXECI:   state <= ALUWB;
        default: state <= FETCH;
      endcase
  assign exec = state == EXECR || state == EXECI;
  assign wb   = state == MEMWB || state == ALUWB;
  alu_decoder u_dec (
    .Funct      (Funct),
    .ALUOp      (exec),
    .ALUControl (ALUControl),
    .FlagW      (dec_fw),
    .NoWrite    (dec_nw)
  );
  // Write enables are gated by rst_n so nothing fires while the reset is held.
  assign IRWrite   = rst_n && state == FETCH;
  assign NextPC    = rst_n && state == FETCH;
  assign RegW      = rst_n && wb;
  assign MemW      = rst_n && state == MEMWR;
  assign FlagW     = rst_n ? dec_fw : 2'b00;
  assign NoWrite   = state == ALUWB && dec_nw;
  assign PCS       = rst_n && (state == BRANCH || (wb && Rd == PC_REG && !NoWrite));
  assign AdrSrc    = state == MEMRD || state == MEMWR;
  assign ALUSrcA   = state == FETCH || state == DECODE;
  assign ALUSrcB   = ALUSrcA ? 2'b10 :
                     (state == MEMADR || state == EXECI || state == BRANCH) ? 2'b01 : 2'b00;
  assign ResultSrc = state == MEMWB ? 2'b01 : state == ALUWB ? 2'b00 : 2'b10;
  assign ImmSrc    = Op;
  assign RegSrc    = {Op == OP_MEM && !Funct[0], Op == OP_BR};
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: directed instruction sequences checked against hand-derived control vectors
module tb_multicycle_control_fsm;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] Op = 2'b00;
  logic [5:0] Funct = 6'b0;
  logic [3:0] Rd = 4'd0;
  logic       IRWrite, NextPC, AdrSrc, ALUSrcA, PCS, RegW, MemW, NoWrite;
  logic [1:0] ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc, FlagW;
  logic [7:0] sel, wr, rs;
  int         applied = 0;
  int         miscompares = 0;
  multicycle_control_fsm dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Op         (Op),
    .Funct      (Funct),
    .Rd         (Rd),
    .IRWrite    (IRWrite),
    .NextPC     (NextPC),
    .AdrSrc     (AdrSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .ALUControl (ALUControl),
    .ImmSrc     (ImmSrc),
    .RegSrc     (RegSrc),
    .PCS        (PCS),
    .RegW       (RegW),
    .MemW       (MemW),
    .NoWrite    (NoWrite),
    .FlagW      (FlagW)
  );
  always #5 clk = ~clk;
  assign sel = {IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc};
  assign wr  = {RegW, MemW, PCS, NoWrite, FlagW, ALUControl};
  assign rs  = {4'b0, RegSrc, ImmSrc};
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    applied++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic load(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd);
    Op = op;
    Funct = f;
    Rd = rd;
  endtask
  initial begin
    @(negedge clk);
    chk("rst_sel", sel, 8'b0001_1010);
    chk("rst_wr", wr, 8'b0000_0000);
    rst_n = 1'b1;
    #1;
    chk("fetch0_sel", sel, 8'b1101_1010);
    load(2'b00, 6'b101001, 4'd1);
    tick; chk("adds_dec_sel", sel, 8'b0001_1010);
    chk("adds_dec_wr", wr, 8'b0000_0000);
    tick; chk("adds_exe_sel", sel, 8'b0000_0110);
    chk("adds_exe_wr", wr, 8'b0000_1100);
    tick; chk("adds_wb_sel", sel, 8'b0000_0000);
    chk("adds_wb_wr", wr, 8'b1000_0000);
    tick; chk("adds_fetch", sel, 8'b1101_1010);
    load(2'b00, 6'b010101, 4'd3);
    tick; tick; chk("cmp_exe_sel", sel, 8'b0000_0010);
    chk("cmp_exe_wr", wr, 8'b0000_1101);
    tick; chk("cmp_wb_wr", wr, 8'b1001_0000);
    tick; load(2'b00, 6'b100001, 4'd15);
    tick; tick; chk("ands_exe_wr", wr, 8'b0000_1010);
    tick; chk("ands_pc_wb_wr", wr, 8'b1010_0000);
    tick; load(2'b00, 6'b011000, 4'd2);
    tick; tick; chk("orr_exe_wr", wr, 8'b0000_0011);
    tick; chk("orr_wb_wr", wr, 8'b1000_0000);
    tick; load(2'b01, 6'b011001, 4'd15);
    tick; chk("ldr_dec_rs", rs, 8'b0000_0001);
    tick; chk("ldr_adr_sel", sel, 8'b0000_0110);
    chk("ldr_adr_wr", wr, 8'b0000_0000);
    tick; chk("ldr_rd_sel", sel, 8'b0010_0010);
    chk("ldr_rd_wr", wr, 8'b0000_0000);
    tick; chk("ldr_wb_sel", sel, 8'b0000_0001);
    chk("ldr_wb_wr", wr, 8'b1010_0000);
    tick; chk("ldr_fetch", sel, 8'b1101_1010);
    load(2'b01, 6'b011000, 4'd2);
    tick; chk("str_dec_rs", rs, 8'b0000_1001);
    tick; chk("str_adr_wr", wr, 8'b0000_0000);
    tick; chk("str_wr_sel", sel, 8'b0010_0010);
    chk("str_wr_wr", wr, 8'b0100_0000);
    tick; chk("str_fetch_sel", sel, 8'b1101_1010);
    chk("str_fetch_wr", wr, 8'b0000_0000);
    load(2'b10, 6'b000000, 4'd0);
    tick; chk("b_dec_rs", rs, 8'b0000_0110);
    tick; chk("b_br_sel", sel, 8'b0000_0110);
    chk("b_br_wr", wr, 8'b0010_0000);
    tick; chk("b_fetch", sel, 8'b1101_1010);
    load(2'b11, 6'b101001, 4'd15);
    tick; tick; chk("ill_unk_sel", sel, 8'b0000_0010);
    chk("ill_unk_wr", wr, 8'b0000_0000);
    tick; chk("ill_fetch", sel, 8'b1101_1010);
    load(2'b01, 6'b011001, 4'd1);
    tick; tick; tick; chk("rstmid_rd_sel", sel, 8'b0010_0010);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_sel", sel, 8'b0001_1010);
    chk("rstmid_wr", wr, 8'b0000_0000);
    tick; chk("rstmid_hold_sel", sel, 8'b0001_1010);
    chk("rstmid_hold_wr", wr, 8'b0000_0000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_fetch", sel, 8'b1101_1010);
    tick; chk("rel_dec", sel, 8'b0001_1010);
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
